// File: rtl/data_cache_ctrl.sv
// ---------------------------------------------------------------------------
// data_cache_ctrl
// Direct-mapped, write-back, write-allocate data cache controller.
// Geometry: 8 blocks x 16 bytes (four 32-bit words per block).
//
// Ports
//   CLK            rising-edge clock
//   RESET          synchronous active-low reset
//   read / write   CPU load / store request (both together acts as a store)
//   address        CPU byte address
//   func3          access width: x00 byte, x01 half, x10 word
//   writedata      store data, LSB-aligned
//   readdata       addressed data shifted down by the byte offset, zero fill
//   busywait       stalls the CPU while a request cannot be served
//   mem_read       block fetch request to memory
//   mem_write      block write-back request to memory
//   mem_address    memory block address (byte address >> 4)
//   mem_writedata  block being written back
//   mem_readdata   block returned by memory
//   mem_busywait   memory still working on the current request
// ---------------------------------------------------------------------------
module data_cache_ctrl (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         read,
    input  logic         write,
    input  logic [31:0]  address,
    input  logic [2:0]   func3,
    input  logic [31:0]  writedata,
    output logic [31:0]  readdata,
    output logic         busywait,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_address,
    output logic [127:0] mem_writedata,
    input  logic [127:0] mem_readdata,
    input  logic         mem_busywait
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;

    state_t       r_state;
    state_t       w_nextState;

    logic [127:0] r_data [8];
    logic [24:0]  r_tag  [8];
    logic [7:0]   r_valid;
    logic [7:0]   r_dirty;
    logic [127:0] r_fill;

    logic [24:0]  w_tag;
    logic [2:0]   w_index;
    logic [1:0]   w_wordSel;
    logic [1:0]   w_byteSel;
    logic         w_hit;
    logic         w_writeHit;
    logic [31:0]  w_oldWord;
    logic [31:0]  w_laneData;
    logic [3:0]   w_laneMask;
    logic [31:0]  w_mergedWord;

    assign w_tag     = address[31:7];
    assign w_index   = address[6:4];
    assign w_wordSel = address[3:2];
    assign w_byteSel = address[1:0];

    assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_writeHit = (r_state == IDLE) && write && w_hit;
    assign busywait   = (read || write) && !((r_state == IDLE) && w_hit);

    assign w_oldWord  = r_data[w_index][{w_wordSel, 5'b0} +: 32];

    // Loads return the whole word shifted down so the addressed byte lands
    // in bit 0; the CPU picks the width it needs from the low bits.
    assign readdata = (read && w_hit) ? (w_oldWord >> {w_byteSel, 3'b0}) : 32'd0;

    // Store data is replicated across the lanes so each enabled lane can
    // simply take its own slice; misaligned halves/words align downwards.
    always_comb begin
        w_laneData = writedata;
        w_laneMask = 4'b1111;
        case (func3)
            3'b000, 3'b100: begin
                w_laneData = {4{writedata[7:0]}};
                w_laneMask = 4'b0001 << w_byteSel;
            end
            3'b001, 3'b101: begin
                w_laneData = {2{writedata[15:0]}};
                w_laneMask = w_byteSel[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_laneData = writedata;
                w_laneMask = 4'b1111;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            w_mergedWord[8*i +: 8] = w_laneMask[i] ? w_laneData[8*i +: 8] : w_oldWord[8*i +: 8];
        end
    end

    // State register and the per-block valid/dirty flags; these are the only
    // things reset clears, so a reset mid-miss drops the fill and any dirty data.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= IDLE;
            r_valid <= 8'd0;
            r_dirty <= 8'd0;
        end else begin
            r_state <= w_nextState;
            if (r_state == UPDATE) begin
                r_valid[w_index] <= 1'b1;
                r_dirty[w_index] <= 1'b0;
            end else if (w_writeHit) begin
                r_dirty[w_index] <= 1'b1;
            end
        end
    end

    // Tag and data storage are not reset; they are only meaningful once the
    // matching valid bit is set. Writes are suppressed while reset is held.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            if (r_state == UPDATE) begin
                r_data[w_index] <= r_fill;
                r_tag[w_index]  <= w_tag;
            end else if (w_writeHit) begin
                r_data[w_index][{w_wordSel, 5'b0} +: 32] <= w_mergedWord;
            end
            if ((r_state == ALLOCATE) && !mem_busywait) begin
                r_fill <= mem_readdata;
            end
        end
    end

    // Miss handling: write back a dirty victim first, then fetch the new
    // block, then install it in a single UPDATE cycle so the retry hits.
    always_comb begin
        w_nextState   = r_state;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = 28'd0;
        mem_writedata = 128'd0;
        case (r_state)
            IDLE: begin
                if ((read || write) && !w_hit) begin
                    w_nextState = (r_valid[w_index] && r_dirty[w_index]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_write     = 1'b1;
                mem_address   = {r_tag[w_index], w_index};
                mem_writedata = r_data[w_index];
                if (!mem_busywait) begin
                    w_nextState = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_read    = 1'b1;
                mem_address = address[31:4];
                if (!mem_busywait) begin
                    w_nextState = UPDATE;
                end
            end
            UPDATE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_cache_ctrl
// Directed self-checking bench for data_cache_ctrl. The memory side is driven
// by hand from the stimulus sequence; expected values are worked out below.
// ---------------------------------------------------------------------------
module tb_data_cache_ctrl;

    logic         CLK;
    logic         RESET;
    logic         read;
    logic         write;
    logic [31:0]  address;
    logic [2:0]   func3;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic         busywait;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int checkCount;
    int errorCount;

    data_cache_ctrl dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .read          (read),
        .write         (write),
        .address       (address),
        .func3         (func3),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    // Free-running clock, 10 time units per cycle
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive a CPU request and let the combinational outputs settle
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [2:0] f3, input logic [31:0] wd);
        read      = rd;
        write     = wr;
        address   = addr;
        func3     = f3;
        writedata = wd;
        #1;
    endtask

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Directed sequence
    initial begin
        checkCount   = 0;
        errorCount   = 0;
        RESET        = 1'b0;
        read         = 1'b0;
        write        = 1'b0;
        address      = 32'd0;
        func3        = 3'b010;
        writedata    = 32'd0;
        mem_readdata = 128'd0;
        mem_busywait = 1'b1;

        // Reset state
        tick();
        tick();
        RESET = 1'b1;
        #1;
        checkOutput("rst_mem_read",  mem_read,  0);
        checkOutput("rst_mem_write", mem_write, 0);
        checkOutput("rst_busywait",  busywait,  0);
        checkOutput("rst_readdata",  readdata,  0);

        // Cold read miss at 0x40 (index 4, tag 0)
        applyStimulus(1, 0, 32'h0000_0040, 3'b010, 32'd0);
        checkOutput("miss_busy", busywait, 1);
        tick();
        checkOutput("alloc_read", mem_read, 1);
        checkOutput("alloc_addr", mem_address, 28'h000_0004);
        checkOutput("alloc_nowrite", mem_write, 0);
        mem_readdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hDDCC_BBAA};
        mem_busywait = 1'b0;
        tick();
        checkOutput("update_mem_read", mem_read, 0);
        checkOutput("update_busy", busywait, 1);
        mem_busywait = 1'b1;
        tick();
        checkOutput("fill_busy", busywait, 0);
        checkOutput("fill_readdata", readdata, 32'hDDCC_BBAA);

        // Byte store hit then reads back
        applyStimulus(0, 1, 32'h0000_0041, 3'b000, 32'hFFFF_FF5A);
        checkOutput("sb_busy", busywait, 0);
        tick();
        applyStimulus(1, 0, 32'h0000_0040, 3'b010, 32'd0);
        checkOutput("lw_after_sb", readdata, 32'hDDCC_5AAA);
        applyStimulus(1, 0, 32'h0000_0041, 3'b100, 32'd0);
        checkOutput("lbu_0x41", readdata, 32'h00DD_CC5A);

        // Half store at 0x42 fills lanes 2 and 3
        applyStimulus(0, 1, 32'h0000_0042, 3'b001, 32'h0000_1234);
        checkOutput("sh_busy", busywait, 0);
        tick();
        applyStimulus(1, 0, 32'h0000_0040, 3'b010, 32'd0);
        checkOutput("lw_after_sh", readdata, 32'h1234_5AAA);

        // Conflicting store to 0xC0 evicts the dirty block
        applyStimulus(0, 1, 32'h0000_00C0, 3'b010, 32'hCAFE_F00D);
        checkOutput("conflict_busy", busywait, 1);
        tick();
        checkOutput("wb_write", mem_write, 1);
        checkOutput("wb_read", mem_read, 0);
        checkOutput("wb_addr", mem_address, 28'h000_0004);
        checkOutput("wb_data", mem_writedata,
                    {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1234_5AAA});
        mem_busywait = 1'b0;
        tick();
        checkOutput("wb2alloc_read", mem_read, 1);
        checkOutput("wb2alloc_write", mem_write, 0);
        checkOutput("wb2alloc_addr", mem_address, 28'h000_000C);
        mem_readdata = {32'h8888_8888, 32'h7777_7777, 32'h6666_6666, 32'h5555_5555};
        tick();
        mem_busywait = 1'b1;
        checkOutput("upd2_mem_read", mem_read, 0);
        tick();
        checkOutput("sw_retry_busy", busywait, 0);
        tick();

        // Evict 0xC0 (now dirty) by reading 0x40 again
        applyStimulus(1, 0, 32'h0000_0040, 3'b010, 32'd0);
        tick();
        checkOutput("wb2_write", mem_write, 1);
        checkOutput("wb2_addr", mem_address, 28'h000_000C);
        checkOutput("wb2_data", mem_writedata,
                    {32'h8888_8888, 32'h7777_7777, 32'h6666_6666, 32'hCAFE_F00D});
        mem_busywait = 1'b0;
        tick();
        checkOutput("alloc3_addr", mem_address, 28'h000_0004);
        mem_readdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1234_5AAA};
        tick();
        mem_busywait = 1'b1;
        tick();
        checkOutput("refill_readdata", readdata, 32'h1234_5AAA);

        // Block refilled by UPDATE is clean: a conflicting read goes straight to ALLOCATE
        applyStimulus(1, 0, 32'h0000_00C4, 3'b010, 32'd0);
        tick();
        checkOutput("clean_no_wb", mem_write, 0);
        checkOutput("clean_alloc_addr", mem_address, 28'h000_000C);

        // Memory stalls for five cycles inside ALLOCATE
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("stall_read_%0d", i), mem_read, 1);
            checkOutput($sformatf("stall_busy_%0d", i), busywait, 1);
            tick();
        end
        mem_readdata = {32'h8888_8888, 32'h7777_7777, 32'h6666_6666, 32'hCAFE_F00D};
        mem_busywait = 1'b0;
        #1;
        checkOutput("stall_last_read", mem_read, 1);
        tick();
        checkOutput("stall_update_read", mem_read, 0);
        checkOutput("stall_update_busy", busywait, 1);
        mem_busywait = 1'b1;
        tick();
        checkOutput("word1_readdata", readdata, 32'h6666_6666);

        // Reset in the middle of ALLOCATE
        applyStimulus(1, 0, 32'h0000_0080, 3'b010, 32'd0);
        tick();
        checkOutput("pre_rst_read", mem_read, 1);
        checkOutput("pre_rst_addr", mem_address, 28'h000_0008);
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        #1;
        checkOutput("midrst_mem_read", mem_read, 0);
        checkOutput("midrst_busy", busywait, 1);
        tick();
        checkOutput("remiss_read", mem_read, 1);
        mem_readdata = {32'h0, 32'h0, 32'h0, 32'h1122_3344};
        mem_busywait = 1'b0;
        tick();
        mem_busywait = 1'b1;
        tick();
        checkOutput("remiss_readdata", readdata, 32'h1122_3344);

        // Simultaneous read and write act as a store, no stall
        applyStimulus(1, 1, 32'h0000_0080, 3'b010, 32'hA5A5_A5A5);
        checkOutput("rw_busy", busywait, 0);
        tick();
        applyStimulus(1, 0, 32'h0000_0080, 3'b010, 32'd0);
        checkOutput("rw_readback", readdata, 32'hA5A5_A5A5);
        applyStimulus(1, 0, 32'h0000_0180, 3'b010, 32'd0);
        tick();
        checkOutput("rw_dirty_wb", mem_write, 1);
        checkOutput("rw_wb_addr", mem_address, 28'h000_0008);
        checkOutput("rw_wb_data", mem_writedata, {96'd0, 32'hA5A5_A5A5});

        // Request dropped mid-miss: the transaction still runs to UPDATE
        applyStimulus(0, 0, 32'h0000_0180, 3'b010, 32'd0);
        mem_busywait = 1'b0;
        tick();
        checkOutput("drop_alloc_read", mem_read, 1);
        checkOutput("drop_alloc_addr", mem_address, 28'h000_0018);
        tick();
        checkOutput("drop_update_read", mem_read, 0);
        checkOutput("drop_update_busy", busywait, 0);
        mem_busywait = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/data_cache_ctrl.md
DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 The block SHALL take one clock and a synchronous, active-low reset: CLK  input  1  rising-edge clock; RESET  input  1  synchronous active-low reset (0 = reset, sampled on CLK rising edge).
REQ-002 CPU side, all lines SHALL be: read  input  1  load request; write  input  1  store request; address  input  32  byte address; func3  input  3  access width (000 byte, 001 half, 010 word, 100/101 same as 000/001 for reads); writedata  input  32  store data, zero-extended, LSB-aligned; readdata  output  32  addressed data, LSB-aligned; busywait  output  1  stall CPU.
REQ-003 Memory side, all lines SHALL be: mem_read  output  1; mem_write  output  1; mem_address  output  28  block address; mem_writedata  output  128; mem_readdata  input  128; mem_busywait  input  1.
REQ-004 Parameters SHALL be: none; geometry is fixed at 8 blocks x 16 bytes, direct-mapped, write-back, write-allocate.

Function
REQ-005 Address split SHALL be tag=address[31:7] (25 b), index=address[6:4], word=address[3:2], byte=address[1:0].
REQ-006 Hit SHALL be valid[index] && tag[index]==address tag, evaluated combinationally.
REQ-007 busywait SHALL equal (read|write) && !(state==IDLE && hit), combinationally.
REQ-008 Read hit: readdata SHALL equal selected word >> (8*byte) in the same cycle, zero fill; with no request, readdata SHALL be 0.
REQ-009 Write hit: on the next rising edge the cache SHALL write only the enabled bytes and set dirty[index]: byte -> lane byte from writedata[7:0]; half -> lanes {byte[1],0},{byte[1],1} from writedata[15:0]; word -> all four lanes.
REQ-010 Misaligned half (byte[0]=1) SHALL be aligned down to byte[1]; misaligned word SHALL be aligned down to the word.
REQ-011 read && write together SHALL be treated as write.
REQ-012 FSM states SHALL be IDLE, WRITEBACK, ALLOCATE, UPDATE.
REQ-013 IDLE: on miss, the FSM SHALL go to WRITEBACK if valid&&dirty, else ALLOCATE.
REQ-014 WRITEBACK: the block SHALL drive mem_write=1, mem_address={stored tag,index}, mem_writedata=stored block; on mem_busywait=0 it SHALL go to ALLOCATE.
REQ-015 ALLOCATE: the block SHALL drive mem_read=1, mem_address=address[31:4]; on mem_busywait=0 it SHALL capture mem_readdata and go to UPDATE.
REQ-016 UPDATE (1 cycle): the block SHALL write the block, tag, valid=1, dirty=0, then return to IDLE; the retried access then hits.
REQ-017 Outside WRITEBACK/ALLOCATE, mem_read, mem_write, mem_address and mem_writedata SHALL be 0.
REQ-018 The CPU SHALL hold read/write/address/func3/writedata stable while busywait=1; the block SHALL NOT latch them.
REQ-019 If the request drops mid-miss, the in-flight memory transaction SHALL still complete and the block SHALL be filled.
REQ-020 Miss latency SHALL be 1 (UPDATE) + memory cycles, plus writeback cycles if dirty.

Reset
REQ-021 With RESET=0 at a rising edge, the block SHALL set state=IDLE and clear all valid and dirty bits; tags and data need not be reset.
REQ-022 From the cycle after reset, mem_read=0 and mem_write=0; with no request, busywait=0 and readdata=0.
REQ-023 Reset mid-WRITEBACK or mid-ALLOCATE SHALL abort to IDLE, discard the fill, and lose dirty data.

Verification
REQ-024 After reset, read 0x00000040 word: the bench SHALL see busywait=1, ALLOCATE with mem_address=0x0000004; memory returns 128'h...DDCCBBAA at word0; after UPDATE, readdata=0xDDCCBBAA with busywait=0.
REQ-025 Sequence: sb 0xFFFFFF5A to 0x41 (hit) -> no stall; then lw 0x40 -> 0xDDCC5AAA; then lbu-mode read 0x41 -> readdata=0x00DDCC5A.
REQ-026 Sequence: sh 0x1234 to 0x42, then write a conflicting tag 0x000000C0 -> WRITEBACK at mem_address=0x0000004 with the modified block, then ALLOCATE at 0x000000C; dirty clear after UPDATE.
REQ-027 With mem_busywait held 5 cycles in ALLOCATE: mem_read stays 1 for all 5 cycles, busywait stays 1 throughout, and the FSM enters UPDATE exactly one edge after mem_busywait falls.
REQ-028 Assert RESET=0 during ALLOCATE -> next cycle mem_read=0, state IDLE; a re-read of the same address misses again.
REQ-029 Read and write simultaneously to a hit line -> write performed and dirty set, with no stall.
